// File: rtl/eth_tx_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_rr_arbiter_pkg
// Description : Shared definitions for the 10G TX round-robin arbiter.
//               These are the arbiter FSM state encodings, the MAC AXI-Stream
//               bus widths and the maximum frame length.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_tx_rr_arbiter_pkg;

  // MAC user-side AXI-Stream geometry
  localparam int C_DATA_W = 64;
  localparam int C_KEEP_W = 8;

  // Largest jumbo frame accepted before truncation, in bytes and in beats
  localparam int C_MAX_PKT_BYTES  = 9600;
  localparam int C_MAX_BEATS_DFLT = C_MAX_PKT_BYTES / C_KEEP_W;

  // Arbiter FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DROP = 2'd2
  } arb_state_e;

endpackage : eth_tx_rr_arbiter_pkg
`default_nettype wire

// File: rtl/eth_tx_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_rr_arbiter_if
// Description : Stream bundle around the TX arbiter. It holds the
//               P_SRC_NUM source streams (s_axis_*, flattened per source)
//               and the single MAC-facing stream (m_axis_*).
//   s_axis_tvalid/tlast/tuser [P_SRC_NUM]  per-source handshake/sideband
//   s_axis_tdata  [64*P_SRC_NUM]           source k at [64k+63:64k]
//   s_axis_tkeep  [8*P_SRC_NUM]            source k at [8k+7:8k]
//   s_axis_tready [P_SRC_NUM]              per-source ready
//   m_axis_*                               to/from MAC tx_axis_*
// Modports    : slave  - arbiter view (consumes sources, drives MAC)
//               master - environment view (drives sources, acts as MAC)
// Revision    : 1.0 - initial release
// ============================================================================
interface eth_tx_rr_arbiter_if
  import eth_tx_rr_arbiter_pkg::*;
#(
  parameter int P_SRC_NUM = 4
) ();

  logic [P_SRC_NUM-1:0]          s_axis_tvalid;
  logic [C_DATA_W*P_SRC_NUM-1:0] s_axis_tdata;
  logic [C_KEEP_W*P_SRC_NUM-1:0] s_axis_tkeep;
  logic [P_SRC_NUM-1:0]          s_axis_tlast;
  logic [P_SRC_NUM-1:0]          s_axis_tuser;
  logic [P_SRC_NUM-1:0]          s_axis_tready;

  logic                          m_axis_tvalid;
  logic [C_DATA_W-1:0]           m_axis_tdata;
  logic [C_KEEP_W-1:0]           m_axis_tkeep;
  logic                          m_axis_tlast;
  logic                          m_axis_tuser;
  logic                          m_axis_tready;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser,
    output s_axis_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser,
    input  s_axis_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser,
    output m_axis_tready
  );

endinterface : eth_tx_rr_arbiter_if
`default_nettype wire

// File: rtl/eth_tx_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_rr_arbiter_rr_pick
// Description : Combinational rotate-priority picker. It returns the first
//               set request at or above ptr_i, wrapping past P_N-1 to 0.
//   req_i [P_N]      request vector
//   ptr_i [P_PTR_W]  highest-priority index, must be < P_N
//   gnt_o [P_N]      one-hot grant, zero when no request
//   any_o            at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_rr_arbiter_rr_pick #(
  parameter int P_N     = 4,
  parameter int P_PTR_W = 2
) (
  input  logic [P_N-1:0]     req_i,
  input  logic [P_PTR_W-1:0] ptr_i,
  output logic [P_N-1:0]     gnt_o,
  output logic               any_o
);

  logic [2*P_N-1:0] w_req_dbl;
  logic [P_N-1:0]   w_req_rot;
  logic [P_N-1:0]   w_gnt_rot;
  logic [2*P_N-1:0] w_gnt_dbl;

  // Rotate the requests so that index ptr_i lands at bit 0. A fixed
  // lowest-bit-wins priority then applies, and the result is rotated back.
  assign w_req_dbl = {req_i, req_i};
  assign w_req_rot = P_N'(w_req_dbl >> ptr_i);

  // x & -x isolates the lowest set bit
  assign w_gnt_rot = w_req_rot & (~w_req_rot + 1'b1);

  assign w_gnt_dbl = {w_gnt_rot, w_gnt_rot};
  assign gnt_o     = P_N'((w_gnt_dbl << ptr_i) >> P_N);
  assign any_o     = |req_i;

endmodule : eth_tx_rr_arbiter_rr_pick
`default_nettype wire

// File: rtl/eth_tx_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_rr_arbiter
// Description : Packet-granular round-robin arbiter. It shares one 10G MAC
//               TX AXI-Stream among P_SRC_NUM sources. New grants are held
//               off while the link is down. Packets longer than P_MAX_BEATS
//               are cut short: the MAC sees tlast+tuser on the last allowed
//               beat, and the rest of the source packet is sunk.
//   i_clk        TX user clock
//   i_rst        synchronous active-high reset
//   i_link_up    link status; 0 blocks new grants only
//   axis         stream bundle (slave modport): sources in, MAC out
//   o_grant      registered one-hot grant, 0 when idle
//   o_busy       transfer or drop in progress
//   o_trunc_cnt  saturating count of truncated packets
// Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_rr_arbiter
  import eth_tx_rr_arbiter_pkg::*;
#(
  parameter int P_SRC_NUM   = 4,
  parameter int P_MAX_BEATS = C_MAX_BEATS_DFLT,
  parameter int P_CNT_W     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_link_up,
  eth_tx_rr_arbiter_if.slave   axis,
  output logic [P_SRC_NUM-1:0] o_grant,
  output logic                 o_busy,
  output logic [P_CNT_W-1:0]   o_trunc_cnt
);

  localparam int C_IDX_W  = $clog2(P_SRC_NUM);
  localparam int C_BEAT_W = $clog2(P_MAX_BEATS + 1);
  localparam logic [C_BEAT_W-1:0] C_LAST_BEAT = C_BEAT_W'(P_MAX_BEATS - 1);

  arb_state_e           state_q, state_d;
  logic [P_SRC_NUM-1:0] grant_q, grant_d;
  logic [C_IDX_W-1:0]   ptr_q,   ptr_d;
  logic [C_BEAT_W-1:0]  beat_q,  beat_d;
  logic [P_CNT_W-1:0]   trunc_q, trunc_d;

  logic [P_SRC_NUM-1:0] w_pick_gnt;
  logic                 w_pick_any;

  logic                 w_sel_valid;
  logic [C_DATA_W-1:0]  w_sel_data;
  logic [C_KEEP_W-1:0]  w_sel_keep;
  logic                 w_sel_last;
  logic                 w_sel_user;
  logic [C_IDX_W-1:0]   w_ptr_after;

  logic                 w_m_valid;
  logic                 w_m_last;
  logic                 w_m_user;
  logic [P_SRC_NUM-1:0] w_s_ready;
  logic                 w_at_limit;

  eth_tx_rr_arbiter_rr_pick #(
    .P_N     (P_SRC_NUM),
    .P_PTR_W (C_IDX_W)
  ) u_rr_pick (
    .req_i (axis.s_axis_tvalid),
    .ptr_i (ptr_q),
    .gnt_o (w_pick_gnt),
    .any_o (w_pick_any)
  );

  // AND-OR mux of the granted source. It also computes the pointer that
  // follows the granted source, so the next scan starts just after it.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    w_sel_keep  = '0;
    w_sel_last  = 1'b0;
    w_sel_user  = 1'b0;
    w_ptr_after = '0;
    for (int k = 0; k < P_SRC_NUM; k++) begin
      if (grant_q[k]) begin
        w_sel_valid = axis.s_axis_tvalid[k];
        w_sel_data  = axis.s_axis_tdata[k*C_DATA_W +: C_DATA_W];
        w_sel_keep  = axis.s_axis_tkeep[k*C_KEEP_W +: C_KEEP_W];
        w_sel_last  = axis.s_axis_tlast[k];
        w_sel_user  = axis.s_axis_tuser[k];
        w_ptr_after = (k == P_SRC_NUM - 1) ? '0 : C_IDX_W'(k + 1);
      end
    end
  end

  // The cut is flagged on the last allowed beat as soon as that beat is
  // presented, not only at handshake. This keeps tlast/tuser stable while
  // the MAC stalls.
  assign w_at_limit = (beat_q == C_LAST_BEAT) && !w_sel_last;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    beat_d    = beat_q;
    trunc_d   = trunc_q;
    w_m_valid = 1'b0;
    w_m_last  = 1'b0;
    w_m_user  = 1'b0;
    w_s_ready = '0;

    case (state_q)
      ST_IDLE: begin
        if (i_link_up && w_pick_any) begin
          grant_d = w_pick_gnt;
          beat_d  = '0;
          state_d = ST_XFER;
        end
      end

      ST_XFER: begin
        w_m_valid = w_sel_valid;
        w_m_last  = w_sel_last | w_at_limit;
        w_m_user  = w_sel_user | w_at_limit;
        w_s_ready = grant_q & {P_SRC_NUM{axis.m_axis_tready}};
        if (w_sel_valid && axis.m_axis_tready) begin
          beat_d = beat_q + 1'b1;
          if (w_sel_last) begin
            state_d = ST_IDLE;
            grant_d = '0;
            ptr_d   = w_ptr_after;
          end else if (w_at_limit) begin
            state_d = ST_DROP;
            if (trunc_q != '1) begin
              trunc_d = trunc_q + 1'b1;
            end
          end
        end
      end

      ST_DROP: begin
        // Sink the remainder of the runaway packet; MAC sees nothing
        w_s_ready = grant_q;
        if (w_sel_valid && w_sel_last) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = w_ptr_after;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
      trunc_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      trunc_q <= trunc_d;
    end
  end

  assign axis.s_axis_tready = w_s_ready;
  assign axis.m_axis_tvalid = w_m_valid;
  assign axis.m_axis_tdata  = w_sel_data;
  assign axis.m_axis_tkeep  = w_sel_keep;
  assign axis.m_axis_tlast  = w_m_last;
  assign axis.m_axis_tuser  = w_m_user;

  assign o_grant     = grant_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_trunc_cnt = trunc_q;

  a_grant_onehot0 : assert property (@(posedge i_clk) disable iff (i_rst)
    $onehot0(grant_q));

  a_m_stable : assert property (@(posedge i_clk) disable iff (i_rst)
    (axis.m_axis_tvalid && !axis.m_axis_tready) |=>
      (axis.m_axis_tvalid && $stable(axis.m_axis_tdata) && $stable(axis.m_axis_tkeep) &&
       $stable(axis.m_axis_tlast) && $stable(axis.m_axis_tuser)));

endmodule : eth_tx_rr_arbiter
`default_nettype wire
